// File: rtl/pointer_accum_pkg.sv
// Shared types and width/limit helpers for the multi-channel pointer accumulator.
// Used by pointer_accum_alu and pointer_accum_multi.
package pointer_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Widest DW the saturation limits can be derived for.
    localparam int DW_LIMIT = 64;

    function automatic int calc_chw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int calc_lw(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

    function automatic logic [DW_LIMIT-1:0] sat_max(input int dw);
        return (DW_LIMIT'(1) << (dw - 1)) - DW_LIMIT'(1);
    endfunction

    function automatic logic [DW_LIMIT-1:0] sat_min(input int dw);
        return DW_LIMIT'(1) << (dw - 1);
    endfunction

endpackage

// File: rtl/pointer_accum_alu.sv
// Per-word adder for the accumulator datapath: wrap-around by default,
// signed saturating when POINTER_ACCUM_SAT_EN is defined.
module pointer_accum_alu
    import pointer_accum_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] sum_o
);

`ifdef POINTER_ACCUM_SAT_EN
    localparam logic [DW-1:0] SAT_HI = DW'(sat_max(DW));
    localparam logic [DW-1:0] SAT_LO = DW'(sat_min(DW));

    logic [DW-1:0] raw;
    logic          ovf;

    // Overflow only when both operands share a sign and the result flips it.
    always_comb begin
        raw   = a_i + b_i;
        ovf   = (a_i[DW-1] == b_i[DW-1]) && (raw[DW-1] != a_i[DW-1]);
        sum_o = raw;
        if (ovf) begin
            sum_o = a_i[DW-1] ? SAT_LO : SAT_HI;
        end
    end
`else
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/pointer_accum_multi.sv
// Multi-channel accumulate engine: ap_ctrl_hs call reads len words over d_i,
// adds them into the selected channel and returns the sum on d_o. Option macro: POINTER_ACCUM_SAT_EN.
module pointer_accum_multi
    import pointer_accum_pkg::*;
#(
    parameter  int DW     = 32,
    parameter  int NCH    = 4,
    parameter  int MAXLEN = 16,
    localparam int CHW    = calc_chw(NCH),
    localparam int LW     = calc_lw(MAXLEN)
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    input  logic           ap_start,
    output logic           ap_done,
    output logic           ap_idle,
    output logic           ap_ready,
    input  logic [CHW-1:0] ch_sel,
    input  logic [LW-1:0]  len,
    input  logic           clr,
    input  logic [DW-1:0]  d_i,
    input  logic           d_i_ap_vld,
    output logic           d_i_ap_ack,
    output logic [DW-1:0]  d_o,
    output logic           d_o_ap_vld,
    input  logic           d_o_ap_ack
);

    state_e          state_q;
    logic [CHW-1:0]  ch_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   cnt_q;
    logic [DW-1:0]   work_q;
    logic [DW-1:0]   d_o_q;
    logic            vld_q;
    logic            done_q;
    logic            idle_q;
    logic [DW-1:0]   acc_q [NCH];

    logic [CHW-1:0]  ch_d;
    logic [LW-1:0]   len_d;
    logic [LW-1:0]   cnt_d;
    logic [DW-1:0]   sum;

    // Out-of-range channel and length requests are folded at the start of a call.
    always_comb begin
        ch_d = ch_sel;
        if ({1'b0, ch_sel} >= (CHW+1)'(NCH)) begin
            ch_d = CHW'(NCH - 1);
        end
        len_d = len;
        if (len > LW'(MAXLEN)) begin
            len_d = LW'(MAXLEN);
        end
        cnt_d = cnt_q + LW'(1);
    end

    pointer_accum_alu #(
        .DW (DW)
    ) u_alu (
        .a_i   (work_q),
        .b_i   (d_i),
        .sum_o (sum)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            d_o_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
            // NOTE: the bank is a small flat register array, so it is cleared here;
            // a RAM-backed bank could not be reset like this.
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        ch_q    <= ch_d;
                        len_q   <= len_d;
                        cnt_q   <= '0;
                        work_q  <= clr ? '0 : acc_q[ch_d];
                        idle_q  <= 1'b0;
                        state_q <= (len_d == '0) ? WRITE : READ;
                    end
                end
                READ: begin
                    if (d_i_ap_vld) begin
                        work_q <= sum;
                        cnt_q  <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Result is presented one cycle after entering WRITE, then held until taken.
                    if (!vld_q) begin
                        d_o_q <= work_q;
                        vld_q <= 1'b1;
                    end else if (d_o_ap_ack) begin
                        acc_q[ch_q] <= work_q;
                        vld_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: input ack is a combinational echo of vld so READ sustains one word per cycle.
    assign d_i_ap_ack = (state_q == READ) && d_i_ap_vld;
    assign d_o        = d_o_q;
    assign d_o_ap_vld = vld_q;
    assign ap_done    = done_q;
    assign ap_ready   = done_q;
    assign ap_idle    = idle_q;

endmodule

// File: tb/tb_pointer_accum_multi.sv
// Scoreboard bench for pointer_accum_multi: expected sums are queued when a call is
// issued and compared when the result handshake completes.
module tb_pointer_accum_multi;

    localparam int DW     = 32;
    localparam int NCH    = 4;
    localparam int MAXLEN = 16;
    localparam int CHW    = 2;
    localparam int LW     = 5;

    logic           ap_clk = 1'b0;
    logic           ap_rst;
    logic           ap_start;
    logic           ap_done;
    logic           ap_idle;
    logic           ap_ready;
    logic [CHW-1:0] ch_sel;
    logic [LW-1:0]  len;
    logic           clr;
    logic [DW-1:0]  d_i;
    logic           d_i_ap_vld;
    logic           d_i_ap_ack;
    logic [DW-1:0]  d_o;
    logic           d_o_ap_vld;
    logic           d_o_ap_ack;

    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc      = 0;
    logic [DW-1:0]  model [NCH];
    logic [DW-1:0]  stim  [32];
    logic [DW-1:0]  sb_q  [$];

    pointer_accum_multi #(
        .DW     (DW),
        .NCH    (NCH),
        .MAXLEN (MAXLEN)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .ch_sel     (ch_sel),
        .len        (len),
        .clr        (clr),
        .d_i        (d_i),
        .d_i_ap_vld (d_i_ap_vld),
        .d_i_ap_ack (d_i_ap_ack),
        .d_o        (d_o),
        .d_o_ap_vld (d_o_ap_vld),
        .d_o_ap_ack (d_o_ap_ack)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef POINTER_ACCUM_SAT_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
`else
        return a + b;
`endif
    endfunction

    // Offer up to nwords words; stop offering once no ack arrives for 4 cycles.
    task automatic feed(input int nwords, input int gap, output int accepted);
        int tries;
        accepted = 0;
        for (int i = 0; i < nwords; i++) begin
            if (gap > 0 && i > 0) begin
                d_i_ap_vld = 1'b0;
                repeat (gap) @(negedge ap_clk);
            end
            d_i        = stim[i];
            d_i_ap_vld = 1'b1;
            tries      = 0;
            #1;
            while (!d_i_ap_ack && tries < 4) begin
                @(negedge ap_clk);
                #1;
                tries++;
            end
            if (!d_i_ap_ack) break;
            @(negedge ap_clk);
            accepted++;
        end
        d_i_ap_vld = 1'b0;
    endtask

    // ack_wait < 0 ties d_o_ap_ack high for the whole call.
    task automatic run_call(input int ch, input int ln, input bit c, input int nwords,
                            input int gap, input int ack_wait, input bit hold_start,
                            input bit chk_lat);
        int            eff_ch;
        int            eff_len;
        int            accepted;
        int            t0;
        int            waited;
        logic [DW-1:0] e;
        logic [DW-1:0] held;
        bit            stable;
        bit            done_early;

        eff_ch  = (ch >= NCH) ? NCH - 1 : ch;
        eff_len = (ln > MAXLEN) ? MAXLEN : ln;
        e = c ? '0 : model[eff_ch];
        for (int i = 0; i < eff_len; i++) e = model_add(e, stim[i]);
        sb_q.push_back(e);

        ap_start   = 1'b1;
        ch_sel     = CHW'(ch);
        len        = LW'(ln);
        clr        = c;
        d_o_ap_ack = (ack_wait < 0);
        @(negedge ap_clk);
        t0 = cyc;
        if (!hold_start) ap_start = 1'b0;

        feed(nwords, gap, accepted);
        check("words_accepted", 32'(accepted), 32'(eff_len));

        waited = 0;
        while (!d_o_ap_vld && waited < 100) begin
            @(negedge ap_clk);
            waited++;
        end
        if (!d_o_ap_vld) begin
            check("d_o_vld_timeout", 32'(d_o_ap_vld), 32'd1);
            void'(sb_q.pop_front());
            ap_start   = 1'b0;
            d_o_ap_ack = 1'b0;
            return;
        end
        if (chk_lat) check("vld_latency", 32'(cyc - t0), 32'(eff_len + 1));

        held       = d_o;
        stable     = 1'b1;
        done_early = 1'b0;
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge ap_clk);
            if (d_o !== held || !d_o_ap_vld) stable = 1'b0;
            if (ap_done) done_early = 1'b1;
        end
        if (ack_wait > 0) begin
            check("d_o_stable", 32'(stable), 32'd1);
            check("no_early_done", 32'(done_early), 32'd0);
        end

        d_o_ap_ack = 1'b1;
        check("d_o", d_o, sb_q.pop_front());
        model[eff_ch] = e;
        @(negedge ap_clk);
        check("ap_done", 32'(ap_done), 32'd1);
        check("ap_ready", 32'(ap_ready), 32'd1);
        if (chk_lat) check("done_latency", 32'(cyc - t0), 32'(eff_len + 2));
        d_o_ap_ack = 1'b0;
        ap_start   = 1'b0;
        @(negedge ap_clk);
        check("idle_after", 32'({ap_idle, ap_done, d_o_ap_vld}), 32'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst     = 1'b1;
        ap_start   = 1'b0;
        ch_sel     = '0;
        len        = '0;
        clr        = 1'b0;
        d_i        = '0;
        d_i_ap_vld = 1'b0;
        d_o_ap_ack = 1'b0;
        for (int k = 0; k < NCH; k++) model[k] = '0;
        for (int k = 0; k < 32; k++) stim[k] = '0;

        repeat (3) @(negedge ap_clk);
        ap_rst     = 1'b0;
        d_i_ap_vld = 1'b1;
        @(negedge ap_clk);
        #1;
        check("rst_outputs", 32'({ap_done, ap_ready, ap_idle, d_i_ap_ack, d_o_ap_vld}), 32'b00100);
        check("rst_d_o", d_o, 32'd0);
        d_i_ap_vld = 1'b0;

        // Back-to-back words, ack tied high, latency checked.
        stim[0] = 32'd5; stim[1] = 32'd6; stim[2] = 32'd7;
        run_call(1, 3, 1'b1, 3, 0, -1, 1'b0, 1'b1);

        // Continue channel 1, then an untouched channel.
        stim[0] = 32'd1; stim[1] = 32'd1;
        run_call(1, 2, 1'b0, 2, 0, 0, 1'b0, 1'b0);
        stim[0] = 32'd3;
        run_call(2, 1, 1'b0, 1, 0, 0, 1'b0, 1'b0);

        // Producer gaps and consumer back-pressure.
        stim[0] = 32'd100; stim[1] = 32'd200;
        run_call(0, 2, 1'b1, 2, 3, 4, 1'b0, 1'b0);

        // Overflow corners.
        stim[0] = 32'h7FFF_FFFF; stim[1] = 32'h0000_0001;
        run_call(3, 2, 1'b1, 2, 0, 0, 1'b0, 1'b0);
        stim[0] = 32'h8000_0000; stim[1] = 32'hFFFF_FFFF;
        run_call(3, 2, 1'b1, 2, 0, 0, 1'b0, 1'b0);

        // Zero-length call never acks; oversize length clamps to MAXLEN.
        stim[0] = 32'd99;
        run_call(1, 0, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) stim[k] = 32'(k + 1);
        run_call(2, 31, 1'b1, 20, 0, 0, 1'b0, 1'b0);

        // Read every channel back.
        for (int k = 0; k < NCH; k++) run_call(k, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        // ap_start held through the whole call must not trigger a second one.
        stim[0] = 32'd9;
        run_call(0, 1, 1'b0, 1, 0, 1, 1'b1, 1'b0);
        repeat (3) @(negedge ap_clk);
        check("no_second_call", 32'({ap_idle, d_o_ap_vld}), 32'b10);

        // Reset in the middle of a READ aborts the call.
        ap_start = 1'b1; ch_sel = 2'd1; len = 5'd3; clr = 1'b0;
        @(negedge ap_clk);
        ap_start   = 1'b0;
        d_i        = 32'd50;
        d_i_ap_vld = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        #1;
        check("rst_mid_call", 32'({ap_idle, d_i_ap_ack, d_o_ap_vld}), 32'b100);
        ap_rst     = 1'b0;
        d_i_ap_vld = 1'b0;
        for (int k = 0; k < NCH; k++) model[k] = '0;
        @(negedge ap_clk);
        run_call(1, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        run_call(0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
